// File: rtl/scalar_regfile_mw.sv
// Multi-warp scalar register file: registered dual read ports with write-first
// forwarding, plus a per-warp execution-mask divergence stack (register 1).
module scalar_regfile_mw #(
  parameter int NUM_WARPS            = 4,
  parameter int SCALAR_REGS_PER_WARP = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int MASK_STACK_DEPTH     = 4,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RW = $clog2(SCALAR_REGS_PER_WARP)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_en,
  input  logic [WW-1:0]                   rd_warp_id,
  input  logic [RW-1:0]                   rs1_addr,
  input  logic [RW-1:0]                   rs2_addr,
  output logic [DATA_WIDTH-1:0]           rs1,
  output logic [DATA_WIDTH-1:0]           rs2,
  output logic                            rd_valid,
  input  logic                            wr_en,
  input  logic [WW-1:0]                   wr_warp_id,
  input  logic [RW-1:0]                   wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            mask_push,
  input  logic                            mask_pop,
  input  logic [WW-1:0]                   mask_warp_id,
  input  logic [DATA_WIDTH-1:0]           push_mask,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] execution_mask,
  output logic                            mask_err
);

  localparam int SPW = $clog2(MASK_STACK_DEPTH + 1);
  localparam int SIW = (MASK_STACK_DEPTH > 1) ? $clog2(MASK_STACK_DEPTH) : 1;
  localparam logic [RW-1:0] MASK_REG = RW'(1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t          regs    [NUM_WARPS][SCALAR_REGS_PER_WARP];
  word_t          mask_q  [NUM_WARPS];
  word_t          mask_nx [NUM_WARPS];
  word_t          stack   [NUM_WARPS][MASK_STACK_DEPTH];
  logic [SPW-1:0] sp      [NUM_WARPS];

  logic [SPW-1:0] cur_sp;
  logic [SIW-1:0] push_idx, pop_idx;
  logic           mask_op, stack_full, stack_empty, mask_illegal, mask_legal;
  logic           wr_ok;
  word_t          rs1_nx, rs2_nx;

  assign cur_sp       = sp[mask_warp_id];
  assign push_idx     = SIW'(cur_sp);
  assign pop_idx      = SIW'(cur_sp - SPW'(1));
  assign stack_full   = (cur_sp == SPW'(MASK_STACK_DEPTH));
  assign stack_empty  = (cur_sp == '0);
  assign mask_op      = mask_push | mask_pop;
  assign mask_illegal = (mask_push & mask_pop) | (mask_push & stack_full) | (mask_pop & stack_empty);
  assign mask_legal   = mask_op & ~mask_illegal;

  // A mask operation on a warp owns that warp's register 1 for the cycle,
  // even when the operation itself is rejected.
  assign wr_ok = wr_en && (wr_addr != '0) &&
                 !((wr_addr == MASK_REG) && (wr_warp_id == mask_warp_id) && mask_op);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) mask_nx[w] = mask_q[w];
    if (wr_ok && (wr_addr == MASK_REG)) mask_nx[wr_warp_id] = wr_data;
    if (mask_legal) begin
      if (mask_push) mask_nx[mask_warp_id] = mask_q[mask_warp_id] & push_mask;
      else           mask_nx[mask_warp_id] = stack[mask_warp_id][pop_idx];
    end
  end

  // Read data reflects everything committed at this edge (write-first).
  always_comb begin
    rs1_nx = regs[rd_warp_id][rs1_addr];
    if (rs1_addr == '0)
      rs1_nx = '0;
    else if (rs1_addr == MASK_REG)
      rs1_nx = mask_nx[rd_warp_id];
    else if (wr_ok && (wr_warp_id == rd_warp_id) && (wr_addr == rs1_addr))
      rs1_nx = wr_data;

    rs2_nx = regs[rd_warp_id][rs2_addr];
    if (rs2_addr == '0)
      rs2_nx = '0;
    else if (rs2_addr == MASK_REG)
      rs2_nx = mask_nx[rd_warp_id];
    else if (wr_ok && (wr_warp_id == rd_warp_id) && (wr_addr == rs2_addr))
      rs2_nx = wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register and stack arrays are built from resettable flops,
      // not RAM macros, because every entry must clear asynchronously.
      for (int w = 0; w < NUM_WARPS; w++) begin
        mask_q[w] <= '1;
        sp[w]     <= '0;
        for (int r = 0; r < SCALAR_REGS_PER_WARP; r++) regs[w][r]  <= '0;
        for (int d = 0; d < MASK_STACK_DEPTH; d++)     stack[w][d] <= '0;
      end
      rs1      <= '0;
      rs2      <= '0;
      rd_valid <= 1'b0;
      mask_err <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      mask_err <= mask_illegal;
      if (rd_en) begin
        rs1 <= rs1_nx;
        rs2 <= rs2_nx;
      end
      if (wr_ok) regs[wr_warp_id][wr_addr] <= wr_data;
      for (int w = 0; w < NUM_WARPS; w++) mask_q[w] <= mask_nx[w];
      if (mask_legal) begin
        if (mask_push) begin
          stack[mask_warp_id][push_idx] <= mask_q[mask_warp_id];
          sp[mask_warp_id]              <= cur_sp + SPW'(1);
        end else begin
          sp[mask_warp_id] <= cur_sp - SPW'(1);
        end
      end
    end
  end

  always_comb begin
    execution_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      execution_mask[w*DATA_WIDTH +: DATA_WIDTH] = mask_q[w];
  end

endmodule

// File: tb/tb_scalar_regfile_mw.sv
// Self-checking bench for scalar_regfile_mw: directed scenarios followed by
// randomized traffic, compared against a behavioural register/stack model.
module tb_scalar_regfile_mw;

  localparam int NW = 4;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [1:0]    rd_warp_id;
  logic [4:0]    rs1_addr, rs2_addr;
  logic [DW-1:0] rs1, rs2;
  logic          rd_valid;
  logic          wr_en;
  logic [1:0]    wr_warp_id;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          mask_push, mask_pop;
  logic [1:0]    mask_warp_id;
  logic [DW-1:0] push_mask;
  logic [NW*DW-1:0] execution_mask;
  logic          mask_err;

  int checks   = 0;
  int failures = 0;

  scalar_regfile_mw #(
    .NUM_WARPS(NW), .SCALAR_REGS_PER_WARP(NR), .DATA_WIDTH(DW), .MASK_STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_warp_id(rd_warp_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_warp_id(wr_warp_id), .wr_addr(wr_addr), .wr_data(wr_data),
    .mask_push(mask_push), .mask_pop(mask_pop), .mask_warp_id(mask_warp_id),
    .push_mask(push_mask), .execution_mask(execution_mask), .mask_err(mask_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus one queue per warp as the mask stack.
  logic [DW-1:0] m_regs [NW][NR];
  logic [DW-1:0] m_mask [NW];
  logic [DW-1:0] m_stk  [NW][$];
  logic [DW-1:0] exp_rs1, exp_rs2;
  logic          exp_valid, exp_err;

  task automatic check(input string tag, input logic [NW*DW-1:0] got, input logic [NW*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_mask[w] = '1;
      m_stk[w].delete();
      for (int r = 0; r < NR; r++) m_regs[w][r] = '0;
    end
    exp_rs1 = '0; exp_rs2 = '0; exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_read(input int w, input int a);
    if (a == 0) return '0;
    if (a == 1) return m_mask[w];
    return m_regs[w][a];
  endfunction

  // Applies one cycle of requests to the model; reads observe the post-update state.
  task automatic model_step();
    bit mop, err;
    int mw;
    mw  = int'(mask_warp_id);
    mop = mask_push || mask_pop;
    err = (mask_push && mask_pop) ||
          (mask_push && m_stk[mw].size() == SD) ||
          (mask_pop  && m_stk[mw].size() == 0);
    if (wr_en && wr_addr != 0) begin
      if (wr_addr == 1) begin
        if (!(mop && wr_warp_id == mask_warp_id)) m_mask[wr_warp_id] = wr_data;
      end else begin
        m_regs[wr_warp_id][wr_addr] = wr_data;
      end
    end
    if (mop && !err) begin
      if (mask_push) begin
        m_stk[mw].push_back(m_mask[mw]);
        m_mask[mw] = m_mask[mw] & push_mask;
      end else begin
        m_mask[mw] = m_stk[mw].pop_back();
      end
    end
    if (rd_en) begin
      exp_rs1 = model_read(int'(rd_warp_id), int'(rs1_addr));
      exp_rs2 = model_read(int'(rd_warp_id), int'(rs2_addr));
    end
    exp_valid = rd_en;
    exp_err   = err;
  endtask

  task automatic compare_all();
    logic [NW*DW-1:0] em;
    for (int w = 0; w < NW; w++) em[w*DW +: DW] = m_mask[w];
    check("rd_valid", {127'd0, rd_valid}, {127'd0, exp_valid});
    check("rs1", {96'd0, rs1}, {96'd0, exp_rs1});
    check("rs2", {96'd0, rs2}, {96'd0, exp_rs2});
    check("mask_err", {127'd0, mask_err}, {127'd0, exp_err});
    check("execution_mask", execution_mask, em);
  endtask

  task automatic idle();
    rd_en = 0; rd_warp_id = 0; rs1_addr = 0; rs2_addr = 0;
    wr_en = 0; wr_warp_id = 0; wr_addr = 0; wr_data = 0;
    mask_push = 0; mask_pop = 0; mask_warp_id = 0; push_mask = 0;
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
  endtask

  // Reset asserted between edges, with whatever request is currently driven in flight.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("reset_all_ones", execution_mask, '1);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, NR-1));
  endfunction

  function automatic logic [NW*DW-1:0] wmask(input int w);
    logic [NW*DW-1:0] v;
    v = '0;
    v[DW-1:0] = execution_mask[w*DW +: DW];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Reset state seen through the read port.
    idle(); rd_en = 1; rd_warp_id = 2; rs1_addr = 0; rs2_addr = 1; tick();
    check("plan_w2_r0", {96'd0, rs1}, 128'h0);
    check("plan_w2_r1", {96'd0, rs2}, 128'hFFFF_FFFF);

    // Same-cycle write/read forwarding and warp isolation.
    idle(); wr_en = 1; wr_warp_id = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
    rd_en = 1; rd_warp_id = 1; rs1_addr = 5; rs2_addr = 6; tick();
    check("plan_fwd", {96'd0, rs1}, 128'hDEAD_BEEF);
    idle(); rd_en = 1; rd_warp_id = 0; rs1_addr = 5; rs2_addr = 5; tick();
    check("plan_w0_r5", {96'd0, rs1}, 128'h0);
    idle(); tick();

    // Register 0 discards writes.
    idle(); wr_en = 1; wr_warp_id = 1; wr_addr = 0; wr_data = 32'h1234; tick();
    idle(); rd_en = 1; rd_warp_id = 1; rs1_addr = 0; rs2_addr = 5; tick();
    check("plan_r0_zero", {96'd0, rs1}, 128'h0);
    check("plan_r5_kept", {96'd0, rs2}, 128'hDEAD_BEEF);

    // Nested divergence on warp 3.
    idle(); mask_push = 1; mask_warp_id = 3; push_mask = 32'h0000_FFFF; tick();
    check("plan_push1", wmask(3), 128'h0000_FFFF);
    idle(); mask_push = 1; mask_warp_id = 3; push_mask = 32'h0000_00F0; tick();
    check("plan_push2", wmask(3), 128'h0000_00F0);
    idle(); mask_pop = 1; mask_warp_id = 3; tick();
    check("plan_pop1", wmask(3), 128'h0000_FFFF);
    idle(); mask_pop = 1; mask_warp_id = 3; tick();
    check("plan_pop2", wmask(3), 128'hFFFF_FFFF);

    // Overflow on warp 0: the last push is rejected.
    for (int i = 0; i <= SD; i++) begin
      idle(); mask_push = 1; mask_warp_id = 0; push_mask = ~(32'd1 << i); tick();
    end
    check("plan_ovf_err", {127'd0, mask_err}, 128'd1);
    check("plan_ovf_mask", wmask(0), 128'hFFFF_FFF0);
    idle(); tick();

    // Underflow on an empty warp.
    idle(); mask_pop = 1; mask_warp_id = 1; tick();
    check("plan_unf_err", {127'd0, mask_err}, 128'd1);
    check("plan_unf_mask", wmask(1), 128'hFFFF_FFFF);

    // Push and pop together.
    idle(); mask_push = 1; mask_pop = 1; mask_warp_id = 0; push_mask = 32'h0; tick();
    check("plan_pp_err", {127'd0, mask_err}, 128'd1);
    check("plan_pp_mask", wmask(0), 128'hFFFF_FFF0);

    // Collision: the mask push on warp 2 wins over the register-1 write.
    idle(); mask_push = 1; mask_warp_id = 2; push_mask = 32'h0000_000F;
    wr_en = 1; wr_warp_id = 2; wr_addr = 1; wr_data = 32'h0000_00AA;
    rd_en = 1; rd_warp_id = 2; rs1_addr = 1; rs2_addr = 0; tick();
    check("plan_coll_mask", wmask(2), 128'h0000_000F);
    check("plan_coll_rd", {96'd0, rs1}, 128'h0000_000F);

    // Reset with a read in flight.
    idle(); rd_en = 1; rd_warp_id = 2; rs1_addr = 1; rs2_addr = 1;
    mid_reset();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      idle();
      rd_en        = ($urandom_range(0, 3) != 0);
      rd_warp_id   = 2'($urandom_range(0, NW-1));
      rs1_addr     = pick_addr();
      rs2_addr     = pick_addr();
      wr_en        = 1'($urandom_range(0, 1));
      wr_warp_id   = 2'($urandom_range(0, NW-1));
      wr_addr      = pick_addr();
      wr_data      = $urandom;
      mask_warp_id = 2'($urandom_range(0, NW-1));
      push_mask    = $urandom;
      r = $urandom_range(0, 9);
      mask_push = (r < 3) || (r == 6);
      mask_pop  = (r >= 3 && r < 7);
      if ($urandom_range(0, 199) == 0) mid_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
